dmem_responder: RTL and testbench

//  Memory-side end of the CPU data-memory interface: accepts load/store requests
//  (address, write data, we) from the cpu datapath and returns read data.

---
 rtl/dmem_responder_pkg.sv | 21 ++
 rtl/dmem_responder_if.sv | 30 +++
 rtl/dmem_responder_sram_1p.sv | 42 ++++
 rtl/dmem_responder.sv | 154 +++++++++++++++
 tb/tb_dmem_responder.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: default bus geometry,
// FSM state encoding and a small index-width helper.
package dmem_responder_pkg;

  localparam int unsigned DMEM_DATA_W   = 16;
  localparam int unsigned DMEM_ADDR_W   = 16;
  localparam int unsigned DMEM_DEPTH    = 256;
  localparam int unsigned DMEM_WAIT_CYC = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Width of the array index; never below one bit so tiny arrays still elaborate.
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// CPU <-> data-memory handshake bundle.
//  master (cpu side)   : drives req/we/address/wdata, sees rdata/ack/err/busy
//  slave  (memory side): the reverse
interface dmem_responder_if
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DATA_W = DMEM_DATA_W,
  parameter int unsigned ADDR_W = DMEM_ADDR_W
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              err;
  logic              busy;

  modport master (
    output req, we, address, wdata,
    input  rdata, ack, err, busy
  );

  modport slave (
    input  req, we, address, wdata,
    output rdata, ack, err, busy
  );

endinterface

// File: rtl/dmem_responder_sram_1p.sv
// Behavioural single-port synchronous RAM with registered read.
//  clk    : clock (posedge)
//  rst_n  : async active-low reset, clears only the read register
//  en     : access enable
//  we     : 1 = write wdata to mem[addr], 0 = read mem[addr] into rdata
//  addr   : word index
//  wdata  : write data
//  rdata  : registered read data, holds between reads
module sram_1p
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DATA_W = DMEM_DATA_W,
  parameter int unsigned DEPTH  = DMEM_DEPTH,
  parameter int unsigned IDX_W  = idx_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  // Array contents are deliberately not reset.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the CPU data-memory interface. Accepts one load/store
// per req/ack handshake, inserts WAIT_CYC wait states, then pulses ack for one
// cycle. Addresses >= DEPTH complete with err, suppress the write and read 0.
//  clk   : clock (posedge)
//  rst_n : async active-low reset; aborts any transaction in flight
//  bus   : slave side of dmem_responder_if (req/we/address/wdata in,
//          rdata/ack/err/busy out)
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DATA_W   = DMEM_DATA_W,
  parameter int unsigned ADDR_W   = DMEM_ADDR_W,
  parameter int unsigned DEPTH    = DMEM_DEPTH,
  parameter int unsigned WAIT_CYC = DMEM_WAIT_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_responder_if.slave  bus
);

  localparam int unsigned       IDX_W     = idx_width(DEPTH);
  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]        WAIT_INIT = 4'(WAIT_CYC - 1);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              capture;

  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rd_oor_q;

  logic [ADDR_W-1:0] txn_addr;
  logic              txn_we;
  logic              txn_oor;
  logic              enter_resp;

  logic              mem_en;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // With WAIT_CYC == 0 the read is launched on the same edge that captures
  // the request, so the live inputs stand in for the not-yet-captured ones.
  always_comb begin
    txn_addr = addr_q;
    txn_we   = we_q;
    if (state == S_IDLE) begin
      txn_addr = bus.address;
      txn_we   = bus.we;
    end
  end

  assign txn_oor    = ({1'b0, txn_addr} >= DEPTH_C);
  assign enter_resp = (state_nxt == S_RESP) && (state != S_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.req) begin
          capture = 1'b1;
          if (WAIT_CYC == 0) begin
            state_nxt = S_RESP;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = S_RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_RESP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (capture) begin
      addr_q  <= bus.address;
      we_q    <= bus.we;
      wdata_q <= bus.wdata;
    end
  end

  // Remembers whether the most recent completed read was out of range, so
  // rdata reads as zero until the next read replaces it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_oor_q <= 1'b0;
    end else if (enter_resp && !txn_we) begin
      rd_oor_q <= txn_oor;
    end
  end

  // Read fires on the edge entering RESP, write on the edge leaving it; the
  // two can never coincide, so one port is enough.
  always_comb begin
    mem_en = 1'b0;
    mem_we = 1'b0;
    if ((state == S_RESP) && we_q && !txn_oor) begin
      mem_en = 1'b1;
      mem_we = 1'b1;
    end else if (enter_resp && !txn_we && !txn_oor) begin
      mem_en = 1'b1;
    end
  end

  sram_1p #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_sram (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (txn_addr[IDX_W-1:0]),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  assign bus.ack   = (state == S_RESP);
  assign bus.err   = (state == S_RESP) && txn_oor;
  assign bus.busy  = (state != S_IDLE);
  assign bus.rdata = rd_oor_q ? '0 : mem_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances with WAIT_CYC 2, 0 and 5 share
// clock and reset; a shadow memory per instance feeds an expected-result queue.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int unsigned NDUT = 3;

  function automatic int unsigned wc_of(input int unsigned d);
    return (d == 0) ? 2 : (d == 1) ? 0 : 5;
  endfunction

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_a   [NDUT];
  logic        we_a    [NDUT];
  logic [15:0] addr_a  [NDUT];
  logic [15:0] wdata_a [NDUT];
  logic [15:0] rdata_o [NDUT];
  logic        ack_o   [NDUT];
  logic        err_o   [NDUT];
  logic        busy_o  [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    dmem_responder_if #(.DATA_W(16), .ADDR_W(16)) bus ();
    assign bus.req     = req_a[g];
    assign bus.we      = we_a[g];
    assign bus.address = addr_a[g];
    assign bus.wdata   = wdata_a[g];
    assign rdata_o[g]  = bus.rdata;
    assign ack_o[g]    = bus.ack;
    assign err_o[g]    = bus.err;
    assign busy_o[g]   = bus.busy;

    dmem_responder #(
      .DATA_W   (16),
      .ADDR_W   (16),
      .DEPTH    (256),
      .WAIT_CYC (wc_of(g))
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int unsigned lat;
  } exp_t;

  exp_t        sb [$];
  logic [15:0] model   [NDUT][256];
  logic [15:0] last_rd [NDUT];
  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_all(input string tag);
    for (int unsigned d = 0; d < NDUT; d++) begin
      check({tag, "_ack"},   32'(ack_o[d]),   32'd0);
      check({tag, "_busy"},  32'(busy_o[d]),  32'd0);
      check({tag, "_err"},   32'(err_o[d]),   32'd0);
      check({tag, "_rdata"}, 32'(rdata_o[d]), 32'(last_rd[d]));
    end
  endtask

  // Caller is at a negedge with the target instance idle. Returns at a
  // negedge in the IDLE cycle following the ack.
  task automatic txn(input int unsigned d, input logic w, input logic [15:0] a,
                     input logic [15:0] wd, input bit scramble);
    exp_t        e;
    exp_t        got;
    int unsigned n;
    e.err = (a >= 16'h0100);
    if (!w) last_rd[d] = e.err ? 16'h0000 : model[d][a[7:0]];
    else if (!e.err) model[d][a[7:0]] = wd;
    e.rdata = last_rd[d];
    e.lat   = wc_of(d) + 1;
    sb.push_back(e);

    req_a[d]   = 1'b1;
    we_a[d]    = w;
    addr_a[d]  = a;
    wdata_a[d] = wd;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (scramble && !ack_o[d]) begin
        we_a[d]    = 1'($urandom_range(0, 1));
        addr_a[d]  = 16'($urandom);
        wdata_a[d] = 16'($urandom);
      end
    end while (!ack_o[d] && n < 40);
    req_a[d] = 1'b0;

    got = sb.pop_front();
    check("ack",     32'(ack_o[d]),   32'd1);
    check("latency", n,               got.lat);
    check("err",     32'(err_o[d]),   32'(got.err));
    check("rdata",   32'(rdata_o[d]), 32'(got.rdata));
    check("busy",    32'(busy_o[d]),  32'd1);

    @(posedge clk);
    @(negedge clk);
    check("ack_drop",  32'(ack_o[d]),  32'd0);
    check("busy_idle", 32'(busy_o[d]), 32'd0);
    check("err_idle",  32'(err_o[d]),  32'd0);
    check("rdata_hold", 32'(rdata_o[d]), 32'(got.rdata));
  endtask

  initial begin
    rst_n = 1'b0;
    for (int unsigned d = 0; d < NDUT; d++) begin
      req_a[d] = 1'b0; we_a[d] = 1'b0; addr_a[d] = '0; wdata_a[d] = '0;
      last_rd[d] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_all("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Give every word a known value.
    for (int unsigned d = 0; d < NDUT; d++)
      for (int unsigned a = 0; a < 256; a++)
        txn(d, 1'b1, 16'(a), 16'($urandom), 1'b0);

    // Store then load with two wait states.
    txn(0, 1'b1, 16'h00A5, 16'h1234, 1'b0);
    txn(0, 1'b0, 16'h00A5, 16'h0000, 1'b0);
    check("load_a5", 32'(rdata_o[0]), 32'h1234);

    // Reset in the middle of a store's wait phase.
    txn(0, 1'b1, 16'h0005, 16'hBEEF, 1'b0);
    req_a[0] = 1'b1; we_a[0] = 1'b1; addr_a[0] = 16'h0005; wdata_a[0] = 16'h1111;
    @(posedge clk);
    @(negedge clk);
    check("pre_abort_busy", 32'(busy_o[0]), 32'd1);
    rst_n = 1'b0;
    req_a[0] = 1'b0;
    for (int unsigned d = 0; d < NDUT; d++) last_rd[d] = '0;
    #1;
    check_idle_all("async_rst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle_all("post_rst");
    txn(0, 1'b0, 16'h0005, 16'h0000, 1'b0);
    check("aborted_store", 32'(rdata_o[0]), 32'hBEEF);

    // Zero wait states, req held high across two loads.
    req_a[1] = 1'b1; we_a[1] = 1'b0; addr_a[1] = 16'h0001;
    @(posedge clk);
    @(negedge clk);
    check("b2b_ack1",   32'(ack_o[1]),   32'd1);
    check("b2b_rdata1", 32'(rdata_o[1]), 32'(model[1][1]));
    addr_a[1] = 16'h0002;
    @(posedge clk);
    @(negedge clk);
    check("b2b_gap",    32'(ack_o[1]),   32'd0);
    check("b2b_hold",   32'(rdata_o[1]), 32'(model[1][1]));
    @(posedge clk);
    @(negedge clk);
    check("b2b_ack2",   32'(ack_o[1]),   32'd1);
    check("b2b_rdata2", 32'(rdata_o[1]), 32'(model[1][2]));
    req_a[1] = 1'b0;
    last_rd[1] = model[1][2];
    @(posedge clk);
    @(negedge clk);
    check("b2b_idle", 32'(busy_o[1]), 32'd0);

    // Range boundary: index aliasing must not let 0x0100 overwrite word 0.
    txn(0, 1'b1, 16'h0100, 16'hDEAD, 1'b0);
    txn(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    txn(0, 1'b0, 16'h0100, 16'h0000, 1'b0);
    txn(0, 1'b0, 16'h00FF, 16'h0000, 1'b0);
    txn(0, 1'b1, 16'hFFFF, 16'h4242, 1'b0);
    txn(1, 1'b0, 16'h8000, 16'h0000, 1'b0);

    // Inputs disturbed during the wait phase.
    txn(0, 1'b1, 16'h0033, 16'h5A5A, 1'b1);
    txn(2, 1'b1, 16'h0044, 16'hA5A5, 1'b1);
    txn(0, 1'b0, 16'h0033, 16'h0000, 1'b1);
    txn(2, 1'b0, 16'h0044, 16'h0000, 1'b1);

    // Random mix across all wait-state settings.
    for (int unsigned i = 0; i < 1000; i++) begin
      int unsigned d;
      logic [15:0] a;
      d = $urandom_range(0, NDUT - 1);
      a = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(256, 65535))
                                      : 16'($urandom_range(0, 255));
      txn(d, 1'($urandom_range(0, 1)), a, 16'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
